// File: rtl/ahbl_sram_slave.sv
// ahbl_sram_slave
//   AHB-Lite slave backed by a word-organised SRAM. It handles single NONSEQ/SEQ transfers,
//   adds WAIT_STATES data-phase wait cycles, and returns the full read word whatever the
//   transfer size. Writes go through a one-entry posted buffer. The buffer commits on the
//   clock edge after capture and forwards its bytes to reads of the same word. Accesses that
//   are out of range, misaligned or of an illegal size get a two-cycle ERROR response.
//
// Ports
//   sys_clk_i    clock
//   sys_rst_i    asynchronous reset, active-high
//   hsel_i       slave select
//   haddr_i      address-phase address
//   htrans_i     transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hsize_i      transfer size (byte/half/word legal)
//   hwrite_i     1 = write
//   hwdata_i     write data, valid in the data phase
//   hready_i     bus HREADY
//   hrdata_o     read data, zero outside read data phases
//   hreadyout_o  slave ready
//   hresp_o      0 OKAY, 1 ERROR
module ahbl_sram_slave #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            MEM_DEPTH   = 4096,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
    parameter int unsigned            WAIT_STATES = 0
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  hsel_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic [2:0]            hsize_i,
    input  logic                  hwrite_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    input  logic                  hready_i,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    output logic                  hreadyout_o,
    output logic                  hresp_o
);

    localparam int unsigned           IW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0]            WS      = 3'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic [2:0] {StIdle, StWait, StDone, StErr1, StErr2} state_e;

    state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    // Data phase of the currently accepted (legal) transfer
    logic          dp_active_q, dp_write_q;
    logic [IW-1:0] dp_idx_q;
    logic [3:0]    dp_be_q;

    // Posted write buffer
    logic                  buf_valid_q;
    logic [IW-1:0]         buf_idx_q;
    logic [3:0]            buf_be_q;
    logic [DATA_WIDTH-1:0] buf_data_q;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic unused_htrans;
    assign unused_htrans = htrans_i[0];

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] base,
                                                    input logic [3:0]            be,
                                                    input logic [DATA_WIDTH-1:0] data);
        logic [DATA_WIDTH-1:0] r;
        r = base;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    // ---------------- address-phase decode ----------------
    logic                  accept, acc_err, acc_ok, below_base;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IW-1:0]         acc_idx;
    logic [3:0]            acc_be;
    logic                  size_bad, misaligned, range_bad;

    // The borrow out of the subtraction flags addresses below BASE_ADDR
    assign {below_base, offset} = {1'b0, haddr_i} - {1'b0, BASE_ADDR};
    assign size_bad   = hsize_i > 3'b010;
    assign misaligned = (hsize_i == 3'b001 && haddr_i[0]) ||
                        (hsize_i == 3'b010 && haddr_i[1:0] != 2'b00);
    assign range_bad  = below_base || ((offset >> 2) >= DEPTH_A);
    assign acc_err    = size_bad || misaligned || range_bad;
    assign acc_idx    = offset[IW+1:2];

    // Accepts are only taken while the slave is ready for a new address phase
    assign accept = hsel_i && htrans_i[1] && hready_i &&
                    (state_q == StIdle || state_q == StDone);
    assign acc_ok = accept && !acc_err;

    always_comb begin
        acc_be = 4'hF;
        case (hsize_i)
            3'b000:  acc_be = 4'b0001 << haddr_i[1:0];
            3'b001:  acc_be = haddr_i[1] ? 4'b1100 : 4'b0011;
            default: acc_be = 4'hF;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    if (acc_err) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES != 0) begin
                        state_d = StWait;
                        cnt_d   = WS;
                    end
                end
            end
            StWait: begin
                hreadyout_o = 1'b0;
                cnt_d       = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) state_d = StDone;
            end
            StErr1: begin
                hreadyout_o = 1'b0;
                hresp_o     = 1'b1;
                state_d     = StErr2;
            end
            StErr2: begin
                hresp_o = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------- data phase tracking ----------------
    logic dp_done, capture, rd_out;
    assign dp_done = dp_active_q && hreadyout_o;
    assign capture = dp_done && dp_write_q;
    assign rd_out  = dp_done && !dp_write_q;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            dp_active_q <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_idx_q    <= '0;
            dp_be_q     <= '0;
        end else if (hreadyout_o) begin
            dp_active_q <= acc_ok;
            if (acc_ok) begin
                dp_write_q <= hwrite_i;
                dp_idx_q   <= acc_idx;
                dp_be_q    <= acc_be;
            end
        end
    end

    // ---------------- write buffer ----------------
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            buf_valid_q <= 1'b0;
            buf_idx_q   <= '0;
            buf_be_q    <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= capture;
            if (capture) begin
                buf_idx_q  <= dp_idx_q;
                buf_be_q   <= dp_be_q;
                buf_data_q <= hwdata_i;
            end
        end
    end

    // SRAM array: not reset; the old buffer entry commits while a new one may load
    always_ff @(posedge sys_clk_i) begin
        if (buf_valid_q) begin
            for (int b = 0; b < 4; b++) begin
                if (buf_be_q[b]) mem[buf_idx_q][8*b +: 8] <= buf_data_q[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    // The fetch merges the entry committing on this same edge. The output then merges
    // whatever the buffer holds during the data phase, such as a write captured as the read
    // was accepted. Wait cycles refetch so commits that land during the wait are seen.
    logic [IW-1:0] fetch_idx;
    logic          fetch_en, fetch_hit, out_hit;

    assign fetch_en  = acc_ok || (state_q == StWait);
    assign fetch_idx = (state_q == StWait) ? dp_idx_q : acc_idx;
    assign fetch_hit = buf_valid_q && (buf_idx_q == fetch_idx);
    assign out_hit   = buf_valid_q && (buf_idx_q == dp_idx_q);

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            rdata_q <= '0;
        end else if (fetch_en) begin
            rdata_q <= merge(mem[fetch_idx], fetch_hit ? buf_be_q : 4'h0, buf_data_q);
        end
    end

    assign hrdata_o = rd_out ? merge(rdata_q, out_hit ? buf_be_q : 4'h0, buf_data_q) : '0;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench: u_dut0 has zero wait states and u_dut3 has three. The two share the address
// and data buses and are selected one at a time with their own hsel.
module tb_ahbl_sram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel0, hsel3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] hrdata0, hrdata3;
    logic        hreadyout0, hreadyout3, hresp0, hresp3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ahbl_sram_slave #(.WAIT_STATES(0)) u_dut0 (
        .sys_clk_i(clk), .sys_rst_i(rst), .hsel_i(hsel0), .haddr_i(haddr), .htrans_i(htrans),
        .hsize_i(hsize), .hwrite_i(hwrite), .hwdata_i(hwdata), .hready_i(hreadyout0),
        .hrdata_o(hrdata0), .hreadyout_o(hreadyout0), .hresp_o(hresp0)
    );

    ahbl_sram_slave #(.WAIT_STATES(3)) u_dut3 (
        .sys_clk_i(clk), .sys_rst_i(rst), .hsel_i(hsel3), .haddr_i(haddr), .htrans_i(htrans),
        .hsize_i(hsize), .hwrite_i(hwrite), .hwdata_i(hwdata), .hready_i(hreadyout3),
        .hrdata_o(hrdata3), .hreadyout_o(hreadyout3), .hresp_o(hresp3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic s0, input logic s3, input logic wr,
                            input logic [31:0] a, input logic [2:0] sz);
        hsel0  = s0;
        hsel3  = s3;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        htrans = 2'b10;
    endtask

    task automatic set_idle();
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        hwrite = 1'b0;
        htrans = 2'b00;
    endtask

    // Zero-wait read on u_dut0
    task automatic rd0(input string tag, input logic [31:0] a, input logic [31:0] exp);
        set_addr(1'b1, 1'b0, 1'b0, a, 3'b010);
        tick();
        set_idle();
        chk({tag, "_ready"}, {31'd0, hreadyout0}, 32'd1);
        chk({tag, "_data"}, hrdata0, exp);
        tick();
    endtask

    // Word write on u_dut3, including the buffer commit cycle
    task automatic wr3(input string tag, input logic [31:0] a, input logic [31:0] d);
        set_addr(1'b0, 1'b1, 1'b1, a, 3'b010);
        tick();
        set_idle();
        hwdata = d;
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_wait"}, {31'd0, hreadyout3}, 32'd0);
            tick();
        end
        chk({tag, "_done"}, {31'd0, hreadyout3}, 32'd1);
        tick();
        tick();
    endtask

    // Read on u_dut3: exactly three low-ready cycles, then data on the fourth
    task automatic rd3(input string tag, input logic [31:0] a, input logic [31:0] exp);
        set_addr(1'b0, 1'b1, 1'b0, a, 3'b010);
        tick();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_wait_ready"}, {31'd0, hreadyout3}, 32'd0);
            chk({tag, "_wait_data"}, hrdata3, 32'd0);
            tick();
        end
        chk({tag, "_ready"}, {31'd0, hreadyout3}, 32'd1);
        chk({tag, "_resp"}, {31'd0, hresp3}, 32'd0);
        chk({tag, "_data"}, hrdata3, exp);
        tick();
        chk({tag, "_after"}, hrdata3, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required $finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        hwdata = '0;
        haddr  = '0;
        hsize  = 3'b010;
        set_idle();
        #3;
        chk("rst_ready0", {31'd0, hreadyout0}, 32'd1);
        chk("rst_resp0", {31'd0, hresp0}, 32'd0);
        chk("rst_data0", hrdata0, 32'd0);
        chk("rst_ready3", {31'd0, hreadyout3}, 32'd1);
        tick();
        tick();
        rst = 1'b0;

        // 1. idle bus
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ready0", {31'd0, hreadyout0}, 32'd1);
            chk("idle_resp0", {31'd0, hresp0}, 32'd0);
            chk("idle_data0", hrdata0, 32'd0);
            chk("idle_ready3", {31'd0, hreadyout3}, 32'd1);
            chk("idle_data3", hrdata3, 32'd0);
        end

        // 2. write then immediate read of the same word (forwarded)
        set_addr(1'b1, 1'b0, 1'b1, 32'h10, 3'b010);
        tick();
        hwdata = 32'hDEADBEEF;
        set_addr(1'b1, 1'b0, 1'b0, 32'h10, 3'b010);
        chk("t2_wr_ready", {31'd0, hreadyout0}, 32'd1);
        chk("t2_wr_data", hrdata0, 32'd0);
        tick();
        set_idle();
        chk("t2_rd_ready", {31'd0, hreadyout0}, 32'd1);
        chk("t2_rd_data", hrdata0, 32'hDEADBEEF);
        tick();
        chk("t2_after", hrdata0, 32'd0);

        // 3. word, byte lane 1, upper half, then read, all back-to-back
        set_addr(1'b1, 1'b0, 1'b1, 32'h20, 3'b010);
        tick();
        hwdata = 32'h11223344;
        set_addr(1'b1, 1'b0, 1'b1, 32'h21, 3'b000);
        tick();
        hwdata = 32'h0000AA00;
        set_addr(1'b1, 1'b0, 1'b1, 32'h22, 3'b001);
        chk("t3_byte_ready", {31'd0, hreadyout0}, 32'd1);
        tick();
        hwdata = 32'hBBCC0000;
        set_addr(1'b1, 1'b0, 1'b0, 32'h20, 3'b010);
        tick();
        set_idle();
        chk("t3_rd_data", hrdata0, 32'hBBCCAA44);
        tick();
        tick();
        rd0("t3_reread", 32'h20, 32'hBBCCAA44);
        rd0("t2_reread", 32'h10, 32'hDEADBEEF);

        // 4. three wait states
        wr3("t4_wr", 32'h0, 32'hCAFEF00D);
        rd3("t4_rd", 32'h0, 32'hCAFEF00D);

        // 5. error responses
        set_addr(1'b1, 1'b0, 1'b1, 32'h0, 3'b010);
        tick();
        hwdata = 32'h0BADF00D;
        set_idle();
        tick();
        tick();
        set_addr(1'b1, 1'b0, 1'b0, 32'h4000, 3'b010);
        tick();
        set_idle();
        chk("t5_oor_err1_resp", {31'd0, hresp0}, 32'd1);
        chk("t5_oor_err1_ready", {31'd0, hreadyout0}, 32'd0);
        tick();
        chk("t5_oor_err2_resp", {31'd0, hresp0}, 32'd1);
        chk("t5_oor_err2_ready", {31'd0, hreadyout0}, 32'd1);
        tick();
        chk("t5_oor_okay_resp", {31'd0, hresp0}, 32'd0);
        chk("t5_oor_okay_ready", {31'd0, hreadyout0}, 32'd1);
        chk("t5_oor_okay_data", hrdata0, 32'd0);

        set_addr(1'b1, 1'b0, 1'b1, 32'h3, 3'b010);
        tick();
        set_idle();
        hwdata = 32'hFFFFFFFF;
        chk("t5_mis_err1_resp", {31'd0, hresp0}, 32'd1);
        chk("t5_mis_err1_ready", {31'd0, hreadyout0}, 32'd0);
        tick();
        chk("t5_mis_err2_resp", {31'd0, hresp0}, 32'd1);
        chk("t5_mis_err2_ready", {31'd0, hreadyout0}, 32'd1);
        tick();
        chk("t5_mis_okay_resp", {31'd0, hresp0}, 32'd0);
        tick();
        rd0("t5_readback", 32'h0, 32'h0BADF00D);

        set_addr(1'b1, 1'b0, 1'b0, 32'h0, 3'b011);
        tick();
        set_idle();
        chk("t5_size_err1_resp", {31'd0, hresp0}, 32'd1);
        tick();
        tick();

        // 6. reset during the second wait cycle of a write
        wr3("t6_pre", 32'h8, 32'h12345678);
        set_addr(1'b0, 1'b1, 1'b1, 32'h8, 3'b010);
        tick();
        set_idle();
        hwdata = 32'hFFFF0000;
        chk("t6_w1_ready", {31'd0, hreadyout3}, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", {31'd0, hreadyout3}, 32'd1);
        chk("t6_rst_resp", {31'd0, hresp3}, 32'd0);
        chk("t6_rst_data", hrdata3, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        rd3("t6_rd", 32'h8, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
